// File: rtl/spi_slave.sv
// spi_slave: SPI target with 2-flop input synchronizers, runtime mode and
// frame length (1..32 bits), a single-entry TX holding register, an RX
// valid/ready handshake and sticky error status.
module spi_slave #(
  parameter int FRAME_MAX = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk_in,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [4:0]           frame_len,
  input  logic [FRAME_MAX-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_empty,
  output logic [FRAME_MAX-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [2:0]           status,
  input  logic [2:0]           ov_clear
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;

  logic [1:0] sclk_s, mosi_s, cs_s;
  logic       sclk_d, cs_d;
  logic [1:0] warm;
  logic       armed;
  logic       cpol_l, cpha_l;
  logic [4:0] flen_l, cnt;
  logic [FRAME_MAX-1:0] tx_hold, tx_sr, rx_sr;
  logic       miso_q, skip, cont, done_q;

  logic cs_sync, sclk_rise, sclk_fall, lead_e, trail_e, samp_e, shft_e;
  logic cs_fall, word_done, abort, udf_set, ovf_set, cpha_eff;
  logic [4:0] flen_eff;
  logic [FRAME_MAX-1:0] load_word, tx_shl;

  assign cs_sync   = cs_s[1];
  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[1] & sclk_d;
  assign lead_e    = cpol_l ? sclk_fall : sclk_rise;
  assign trail_e   = cpol_l ? sclk_rise : sclk_fall;
  assign samp_e    = cpha_l ? trail_e : lead_e;
  assign shft_e    = cpha_l ? lead_e : trail_e;
  // a falling cs_n only counts once cs_n has been seen high since reset
  assign cs_fall   = armed & cs_d & ~cs_sync;
  assign word_done = (state == SHIFT) & samp_e & (cnt == 5'd0);
  assign abort     = (state == SHIFT) & cs_sync & ~word_done;
  // mode and length are taken from the pins only at frame start
  assign flen_eff  = cont ? flen_l : frame_len;
  assign cpha_eff  = cont ? cpha_l : cpha;
  assign load_word = tx_empty ? '0 : tx_hold;
  assign tx_shl    = tx_sr << 1;
  assign udf_set   = (state == LOAD) & tx_empty;
  assign ovf_set   = done_q & rx_valid & ~rx_ready;
  assign miso_oe   = ~cs_sync;
  assign miso      = miso_q & (state != IDLE);

  // input synchronizers, SCLK/cs_n delayed copies for edge detection, arming
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_s <= 2'b00;
      mosi_s <= 2'b00;
      cs_s   <= 2'b11;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
      warm   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk_in};
      mosi_s <= {mosi_s[0], mosi};
      cs_s   <= {cs_s[0], cs_n};
      sclk_d <= sclk_s[1];
      cs_d   <= cs_s[1];
      warm   <= {warm[0], 1'b1};
      if (warm[1] && cs_sync) armed <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cs_fall) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: begin
        if (word_done)    state_nxt = cs_sync ? IDLE : LOAD;
        else if (cs_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // shift datapath: word setup in LOAD, sample/shift on SCLK edges in SHIFT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      flen_l <= '0;
      cnt    <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      miso_q <= 1'b0;
      skip   <= 1'b0;
      cont   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= word_done;
      case (state)
        IDLE: begin
          cont   <= 1'b0;
          miso_q <= 1'b0;
        end
        LOAD: begin
          if (!cont) begin
            cpol_l <= cpol;
            cpha_l <= cpha;
            flen_l <= frame_len;
          end
          cnt    <= flen_eff;
          tx_sr  <= load_word;
          miso_q <= load_word[flen_eff];
          rx_sr  <= '0;
          // cpha=1: first leading edge must not move the MSB off miso;
          // back-to-back words: the old word's trailing edge is still due
          skip   <= cpha_eff | cont;
        end
        SHIFT: begin
          if (samp_e) begin
            rx_sr <= {rx_sr[FRAME_MAX-2:0], mosi_s[1]};
            cnt   <= cnt - 5'd1;
          end
          if (shft_e) begin
            if (skip) skip <= 1'b0;
            else begin
              tx_sr  <= tx_shl;
              miso_q <= tx_shl[flen_l];
            end
          end
          if (word_done) cont <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // TX holding register; a load coinciding with LOAD refills the freed slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_hold  <= '0;
      tx_empty <= 1'b1;
    end else if (tx_load && (tx_empty || state == LOAD)) begin
      tx_hold  <= tx_data;
      tx_empty <= 1'b0;
    end else if (state == LOAD) begin
      tx_empty <= 1'b1;
    end
  end

  // RX output register and handshake; a completed word lands one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (done_q && (!rx_valid || rx_ready)) begin
      rx_data  <= rx_sr;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // sticky status {frame_err, tx_udf, rx_ovf}; a set beats a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) status <= 3'b000;
    else        status <= (status & ~ov_clear) | {abort, udf_set, ovf_set};
  end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-level SPI master, queue-based RX scoreboard,
// word-level model of the TX holding register and status bits.
module tb_spi_slave;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset, sclk_in, cs_n, mosi, miso, miso_oe, cpol, cpha;
  logic        tx_load, tx_empty, rx_valid, rx_ready;
  logic [4:0]  frame_len;
  logic [31:0] tx_data, rx_data;
  logic [2:0]  status, ov_clear;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  bit          m_tx_full;
  logic [31:0] m_tx_word;
  logic [2:0]  m_status;
  bit          m_rx_held;
  logic [31:0] mo_w[2];
  logic [31:0] tx_w[2];
  bit          tx_have[2];

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
    .frame_len(frame_len), .tx_data(tx_data), .tx_load(tx_load),
    .tx_empty(tx_empty), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .status(status), .ov_clear(ov_clear)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      tx_load  = 1'b0;
      ov_clear = 3'b000;
    end
  endtask

  task automatic load_tx(input logic [31:0] w);
    tx_data = w;
    tx_load = 1'b1;
    if (!m_tx_full) begin m_tx_full = 1; m_tx_word = w; end
    tick(1);
  endtask

  task automatic clear_st(input logic [2:0] v);
    ov_clear = v;
    m_status = m_status & ~v;
    tick(2);
  endtask

  task automatic push_rx(input logic [31:0] w);
    if (!rx_ready && m_rx_held) m_status[0] = 1'b1;
    else begin
      exp_q.push_back(w);
      if (!rx_ready) m_rx_held = 1;
    end
  endtask

  // One cs_n-low frame of nw words. cut>0: after that many sample edges,
  // either raise cs_n (abort) or, with cut_rst, pulse reset.
  task automatic xfer(input bit cp, input bit ch, input int flen, input int nw,
                      input int cut, input bit cut_rst, input bit lat);
    logic [31:0] mask, got, exp_tx;
    int nb;
    nb   = 0;
    mask = (flen == 31) ? 32'hFFFF_FFFF : ((32'd1 << (flen + 1)) - 32'd1);
    cpol = cp; cpha = ch; frame_len = 5'(flen); sclk_in = cp;
    tick(4);
    cs_n = 1'b0;
    tick(2 * HALF);
    chk("miso_oe_active", {31'd0, miso_oe}, 32'd1);
    for (int w = 0; w < nw; w++) begin
      if (m_tx_full) begin exp_tx = m_tx_word & mask; m_tx_full = 0; end
      else begin exp_tx = 32'd0; m_status[1] = 1'b1; end
      got = 32'd0;
      for (int b = flen; b >= 0; b--) begin
        if (ch) sclk_in = ~sclk_in;
        mosi = mo_w[w][b];
        tick(HALF);
        got[b] = miso;
        if (b == flen && w + 1 < nw && tx_have[w+1]) begin
          tx_data = tx_w[w+1];
          tx_load = 1'b1;
          if (!m_tx_full) begin m_tx_full = 1; m_tx_word = tx_w[w+1]; end
        end
        sclk_in = ~sclk_in;
        nb++;
        if (b == 0) begin
          if (w == nw - 1) cs_n = 1'b1;
          push_rx(mo_w[w] & mask);
        end
        if (nb == cut) begin
          if (cut_rst) begin
            reset = 1'b0;
            #1;
            chk("rst_miso", {31'd0, miso}, 32'd0);
            chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
            chk("rst_tx_empty", {31'd0, tx_empty}, 32'd1);
            chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
            chk("rst_rx_data", rx_data, 32'd0);
            chk("rst_status", {29'd0, status}, 32'd0);
            m_tx_full = 0; m_status = 3'b000; m_rx_held = 0;
            cs_n = 1'b1; sclk_in = cp;
            tick(3);
            reset = 1'b1;
            tick(8);
            return;
          end
          tick(HALF);
          sclk_in = cp;
          cs_n = 1'b1;
          m_status[2] = 1'b1;
          chk("miso_partial", got,
              exp_tx & mask & ~((32'd1 << (flen + 1 - nb)) - 32'd1));
          tick(8);
          return;
        end
        if (lat && b == 0 && w == nw - 1) begin
          repeat (3) @(posedge clk);
          #1 chk("rx_valid_early", {31'd0, rx_valid}, 32'd0);
          @(posedge clk);
          #1 chk("rx_valid_latency", {31'd0, rx_valid}, 32'd1);
        end
        tick(HALF);
        if (!ch) sclk_in = ~sclk_in;
      end
      chk("miso_word", got, exp_tx);
    end
    tick(8);
    chk("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
    chk("miso_idle", {31'd0, miso}, 32'd0);
  endtask

  // scoreboard monitor: every accepted RX word must match the next expected one
  always @(negedge clk) begin
    if (reset && rx_valid && rx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected actual=%h required=none", rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rx_data !== mon_e) begin
          errors++;
          $display("FAIL rx_word actual=%h required=%h", rx_data, mon_e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; cs_n = 1'b1; sclk_in = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; frame_len = 5'd7;
    tx_data = 32'd0; tx_load = 1'b0; rx_ready = 1'b1; ov_clear = 3'b000;
    m_tx_full = 0; m_tx_word = 32'd0; m_status = 3'b000; m_rx_held = 0;
    tx_have[0] = 0; tx_have[1] = 0;
    #2 reset = 1'b0;
    #1;
    chk("reset_miso", {31'd0, miso}, 32'd0);
    chk("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("reset_tx_empty", {31'd0, tx_empty}, 32'd1);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_rx_data", rx_data, 32'd0);
    chk("reset_status", {29'd0, status}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(6);

    // mode 0, 8 bits
    load_tx(32'hA5);
    chk("tx_empty_loaded", {31'd0, tx_empty}, 32'd0);
    mo_w[0] = 32'h3C;
    xfer(1'b0, 1'b0, 7, 1, -1, 1'b0, 1'b1);
    chk("m0_status", {29'd0, status}, {29'd0, m_status});
    chk("m0_tx_empty", {31'd0, tx_empty}, 32'd1);

    // mode 3, two 32-bit words under one cs_n, TX refilled mid-word
    mo_w[0] = 32'hDEADBEEF; mo_w[1] = 32'h12345678;
    tx_w[1] = 32'h0BADC0DE; tx_have[1] = 1;
    load_tx(32'hCAFEF00D);
    xfer(1'b1, 1'b1, 31, 2, -1, 1'b0, 1'b1);
    chk("m3_status", {29'd0, status}, {29'd0, m_status});

    // RX overflow: two words without a handshake
    rx_ready = 1'b0;
    load_tx(32'h11); mo_w[0] = 32'h96;
    xfer(1'b0, 1'b0, 7, 1, -1, 1'b0, 1'b0);
    load_tx(32'h22); mo_w[0] = 32'h69;
    xfer(1'b0, 1'b0, 7, 1, -1, 1'b0, 1'b0);
    chk("ovf_status", {29'd0, status}, {29'd0, m_status});
    chk("ovf_rx_data", rx_data, 32'h96);
    chk("ovf_rx_valid", {31'd0, rx_valid}, 32'd1);
    clear_st(3'b001);
    chk("ovf_cleared", {29'd0, status}, {29'd0, m_status});
    rx_ready = 1'b1; m_rx_held = 0;
    tick(4);

    // TX underflow plus abort after 5 of 8 bits
    mo_w[0] = 32'hF0;
    xfer(1'b0, 1'b0, 7, 1, 5, 1'b0, 1'b0);
    chk("abort_status", {29'd0, status}, {29'd0, m_status});
    chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);

    // reset in the middle of a frame, then a clean frame
    mo_w[0] = 32'h81; mo_w[1] = 32'h7E; tx_w[1] = 32'h33; tx_have[1] = 1;
    load_tx(32'h44);
    xfer(1'b0, 1'b0, 7, 2, 4, 1'b1, 1'b0);
    load_tx(32'h5A); mo_w[0] = 32'hC3;
    xfer(1'b0, 1'b0, 7, 1, -1, 1'b0, 1'b1);
    chk("post_rst_status", {29'd0, status}, {29'd0, m_status});

    // randomized frames: mode, length, word count, TX presence
    for (int i = 0; i < 10; i++) begin
      bit cp, ch;
      int fl, nw;
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      fl = $urandom_range(0, 31);
      nw = $urandom_range(1, 2);
      for (int k = 0; k < 2; k++) begin
        mo_w[k] = $urandom;
        tx_w[k] = $urandom;
        tx_have[k] = ($urandom_range(0, 3) != 0);
      end
      if (tx_have[0]) load_tx(tx_w[0]);
      xfer(cp, ch, fl, nw, -1, 1'b0, 1'b1);
      chk("rnd_status", {29'd0, status}, {29'd0, m_status});
      chk("rnd_tx_empty", {31'd0, tx_empty}, {31'd0, !m_tx_full});
      clear_st(3'b111);
    end

    tick(10);
    chk("rx_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: FRAME_MAX, 32, maximum frame width in bits; data ports are FRAME_MAX wide.
REQ-002 clk  input  1  system clock; all internal state is clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 sclk_in  input  1  SPI clock from the external master; asynchronous to clk.
REQ-005 cs_n  input  1  SPI chip select from the master, active-low; asynchronous.
REQ-006 mosi  input  1  serial data from the master; asynchronous.
REQ-007 miso  output  1  serial data to the master.
REQ-008 miso_oe  output  1  output enable for the miso pad driver.
REQ-009 cpol, cpha  input  1 each  SPI mode, sampled at frame start.
REQ-010 frame_len  input  5  frame width minus 1 (0..31 gives 1..32 bits), sampled at frame start.
REQ-011 tx_data  input  32  next word to transmit.
REQ-012 tx_load  input  1  single-cycle strobe that writes tx_data into the TX holding register.
REQ-013 tx_empty  output  1  TX holding register is free.
REQ-014 rx_data  output  32  last received word, right-justified, with upper bits zero.
REQ-015 rx_valid, rx_ready  output, input  1 each  RX valid/ready handshake.
REQ-016 status  output  3  {frame_err, tx_udf, rx_ovf}; each bit is sticky.
REQ-017 ov_clear  input  3  write-1-to-clear pulses, aligned bitwise with status.

Function
REQ-018 sclk_in, cs_n and mosi SHALL each pass through a 2-flop synchronizer; SCLK edges SHALL be detected by comparing the synchronized value with a 1-cycle delayed copy.
REQ-019 The supported SCLK frequency SHALL be at most clk/8.
REQ-020 Edge roles:
- Leading edge is rising when cpol=0 and falling when cpol=1.
- cpha=0: sample mosi on the leading edge; shift miso on the trailing edge.
- cpha=1: shift miso on the leading edge; sample mosi on the trailing edge.
REQ-021 Bit order SHALL be MSB first for both directions.
REQ-022 FSM states: IDLE, LOAD, SHIFT.
- IDLE: on synchronized cs_n falling, go to LOAD.
- LOAD (1 cycle): latch mode and frame_len, and set bit counter = frame_len.
- LOAD, tx_empty=0: copy the TX holding register into the TX shift register and set tx_empty=1.
- LOAD, tx_empty=1: load all zeros into the TX shift register and set tx_udf.
- LOAD: drive miso = bit[frame_len] of the shift register, then go to SHIFT.
- SHIFT: on each sample edge shift in mosi; on each shift edge advance miso.
- SHIFT: when a sample edge occurs at counter=0, the word is complete; return to LOAD if cs_n is still low, otherwise go to IDLE.
REQ-023 When cpha=1, the first shift edge of a frame SHALL NOT advance miso (bit[frame_len] stays on miso).
REQ-024 On word complete, with rx_valid=0: set rx_data and rx_valid on the next clk edge.
REQ-025 On word complete, with rx_valid=1 and no handshake that cycle: set rx_ovf, discard the new word and keep the old rx_data.
REQ-026 rx_valid SHALL clear on the clk edge where rx_valid && rx_ready; a completion in that same cycle is accepted without overflow.
REQ-027 rx_valid SHALL rise exactly 3 clk edges after the clk edge at which sclk_in first presents the final sampling edge level.
REQ-028 tx_load while tx_empty=0 SHALL be ignored.
REQ-029 If tx_load arrives in the same cycle as LOAD, LOAD SHALL take the old contents; the new word is written and tx_empty=0.
REQ-030 Synchronized cs_n rising while in SHIFT with the counter not yet complete SHALL abort the frame: set frame_err, discard the partial word, go to IDLE, and leave rx_valid unchanged.
REQ-031 miso_oe SHALL equal NOT synchronized cs_n; miso SHALL be 0 in IDLE.
REQ-032 A status bit SHALL clear on an ov_clear pulse unless set by an event in the same cycle; set wins.
REQ-033 SCLK edges SHALL be ignored in IDLE and LOAD; cpol, cpha and frame_len changes mid-frame SHALL have no effect.

Reset
REQ-034 Reset assertion SHALL asynchronously force:
- state IDLE;
- miso=0, miso_oe=0;
- tx_empty=1;
- rx_valid=0, rx_data=0;
- status=0;
- counters and shift registers 0;
- synchronizer flops to 1 for cs_n and to 0 for the others.
REQ-035 Reset during SHIFT SHALL drop the frame without setting frame_err; after release, a new frame begins only on a fresh cs_n falling edge.

Verification
REQ-036 Mode 0, frame_len=7, tx=0xA5, master sends 0x3C -> master reads 0xA5; rx_data=0x3C and rx_valid=1 after 8 SCLK edges; status=0.
REQ-037 Mode 3, frame_len=31, cs_n held low for two words with TX reloaded between them, master sends 0xDEADBEEF then 0x12345678 -> both words received in order; miso carries both TX words.
REQ-038 Two frames with rx_ready=0 -> rx_data holds the first word and rx_ovf=1; ov_clear=3'b001 -> status=0.
REQ-039 Frame with tx_empty=1 -> miso all zeros and tx_udf=1; cs_n raised after 5 of 8 bits -> frame_err=1 and rx_valid unchanged.
REQ-040 reset low mid-frame at bit 4 -> all outputs return to their reset values immediately; the next full frame is received correctly.
